// File: rtl/branch_resolve_ctrl.sv
// brc_fifo: small generic synchronous FIFO with a synchronous flush input.
// Latency: a push is visible on o_dat/o_empty one cycle later.
// Backpressure: o_full/o_empty only; the caller must not push when full (unless popping) or pop when empty.
// Ports: i_clk/i_rst (sync, active-low), i_clr (drop all entries), i_push/i_dat, i_pop, o_dat (head), o_full, o_empty.
module brc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd];
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
endmodule

// branch_resolve_ctrl: tracks predicted beqs from ID in order and checks them against RR resolutions.
// Latency: resolve -> update visible next cycle; mispredict -> flush/redirect pulse next cycle, then FLUSH_CYC stall cycles.
// Backpressure: o_res_ready drops when the update buffer is full and not draining, or while flushing; o_stall_id holds ID.
// Ports: i_id_* (branch in ID), i_res_* / o_res_ready (resolution), o_stall_id/o_flush/o_redirect_* (pipeline control),
//        o_upd_* / i_upd_ready (predictor update port), o_mispred_cnt, o_err_underflow (sticky).
module branch_resolve_ctrl #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int UPD_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_br_valid,
  input  logic [15:0] i_id_pc,
  input  logic        i_id_pred_taken,
  input  logic [15:0] i_id_target,
  input  logic        i_res_valid,
  input  logic        i_res_taken,
  output logic        o_res_ready,
  output logic        o_stall_id,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [15:0] o_redirect_pc,
  output logic        o_upd_valid,
  output logic [3:0]  o_upd_idx,
  output logic        o_upd_taken,
  input  logic        i_upd_ready,
  output logic [15:0] o_mispred_cnt,
  output logic        o_err_underflow
);
  localparam int CNTW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic        pred;
    logic [15:0] target;
  } br_ent_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       taken;
  } upd_ent_t;

  state_t         r_state;
  logic [CNTW-1:0] r_cnt;
  logic           r_flush;
  logic [15:0]    r_redir_pc;
  logic [15:0]    r_mis_cnt;
  logic           r_err;

  br_ent_t  w_push_ent;
  br_ent_t  w_head;
  upd_ent_t w_upd_in;
  upd_ent_t w_upd_head;
  logic     w_br_full, w_br_empty, w_upd_full, w_upd_empty;
  logic     w_run, w_pop, w_push, w_mis, w_upd_pop;

  assign w_run     = (r_state == S_RUN);
  assign w_upd_pop = ~w_upd_empty & i_upd_ready;
  // A full update buffer still accepts a resolution when its head drains this cycle.
  assign o_res_ready = w_run & (~w_upd_full | w_upd_pop);
  assign w_pop     = i_res_valid & o_res_ready & ~w_br_empty;
  assign w_mis     = w_pop & (w_head.pred != i_res_taken);
  // A branch entering ID in the mispredict cycle is on the wrong path, so it is dropped.
  assign w_push    = i_id_br_valid & w_run & (~w_br_full | w_pop) & ~w_mis;
  assign o_stall_id = (i_id_br_valid & w_br_full & ~w_pop) | ~w_run;

  assign w_push_ent = '{pc: i_id_pc, pred: i_id_pred_taken, target: i_id_target};
  assign w_upd_in   = '{idx: w_head.pc[3:0], taken: i_res_taken};

  brc_fifo #(.W($bits(br_ent_t)), .DEPTH(DEPTH)) u_br_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_mis),
    .i_push  (w_push),
    .i_dat   (w_push_ent),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_br_full),
    .o_empty (w_br_empty)
  );

  // Every resolution produces an update, including mispredicts; flushes never clear this buffer.
  brc_fifo #(.W($bits(upd_ent_t)), .DEPTH(UPD_DEPTH)) u_upd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (1'b0),
    .i_push  (w_pop),
    .i_dat   (w_upd_in),
    .i_pop   (w_upd_pop),
    .o_dat   (w_upd_head),
    .o_full  (w_upd_full),
    .o_empty (w_upd_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_flush    <= 1'b0;
      r_redir_pc <= '0;
      r_mis_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_flush <= w_mis;
      if (w_mis) begin
        r_redir_pc <= i_res_taken ? w_head.target : (w_head.pc + 16'd1);
        r_mis_cnt  <= r_mis_cnt + 16'd1;
      end
      if (i_res_valid & w_run & w_br_empty) r_err <= 1'b1;
      case (r_state)
        S_RUN: begin
          if (w_mis) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNTW'(FLUSH_CYC);
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_flush          = r_flush;
  assign o_redirect_valid = r_flush;
  assign o_redirect_pc    = r_redir_pc;
  assign o_upd_valid      = ~w_upd_empty;
  assign o_upd_idx        = w_upd_head.idx;
  assign o_upd_taken      = w_upd_head.taken;
  assign o_mispred_cnt    = r_mis_cnt;
  assign o_err_underflow  = r_err;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4, FLUSH_CYC = 2, UPD_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_v, id_pred, res_v, res_t, upd_rdy;
  logic [15:0] id_pc, id_tgt;
  logic        res_ready, stall_id, flush, redir_v, upd_valid, upd_taken, err_uf;
  logic [15:0] redir_pc, mis_cnt;
  logic [3:0]  upd_idx;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .UPD_DEPTH(UPD_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_br_valid(id_v), .i_id_pc(id_pc), .i_id_pred_taken(id_pred), .i_id_target(id_tgt),
    .i_res_valid(res_v), .i_res_taken(res_t), .o_res_ready(res_ready),
    .o_stall_id(stall_id), .o_flush(flush), .o_redirect_valid(redir_v), .o_redirect_pc(redir_pc),
    .o_upd_valid(upd_valid), .o_upd_idx(upd_idx), .o_upd_taken(upd_taken), .i_upd_ready(upd_rdy),
    .o_mispred_cnt(mis_cnt), .o_err_underflow(err_uf)
  );

  // Reference model: in-flight branches and pending updates as queues.
  typedef struct packed {logic [15:0] pc; logic pred; logic [15:0] tgt;} br_t;
  br_t        bq[$];
  logic [4:0] uq[$];
  int         flush_left;
  logic       m_flush, m_err;
  logic [15:0] m_rpc, m_cnt;
  logic       e_run, e_ready, e_pop, e_mis, e_stall, e_push;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete(); uq.delete();
    flush_left = 0; m_flush = 1'b0; m_err = 1'b0; m_rpc = '0; m_cnt = '0;
  endtask

  task automatic eval();
    e_run   = (flush_left == 0);
    e_ready = e_run && ((uq.size() < UPD_DEPTH) || (uq.size() > 0 && upd_rdy));
    e_pop   = res_v && e_ready && (bq.size() > 0);
    e_mis   = e_pop && (bq[0].pred != res_t);
    e_stall = !e_run || (id_v && bq.size() == DEPTH && !e_pop);
    e_push  = id_v && e_run && (bq.size() < DEPTH || e_pop) && !e_mis;
  endtask

  task automatic check_all();
    eval();
    chk("stall_id", stall_id, e_stall);
    chk("res_ready", res_ready, e_ready);
    chk("flush", flush, m_flush);
    chk("redirect_valid", redir_v, m_flush);
    if (m_flush) chk("redirect_pc", redir_pc, m_rpc);
    chk("upd_valid", upd_valid, uq.size() > 0);
    if (uq.size() > 0) begin
      chk("upd_idx", upd_idx, uq[0][4:1]);
      chk("upd_taken", upd_taken, uq[0][0]);
    end
    chk("mispred_cnt", mis_cnt, m_cnt);
    chk("err_underflow", err_uf, m_err);
  endtask

  task automatic model_step();
    br_t h;
    eval();
    if (res_v && e_run && bq.size() == 0) m_err = 1'b1;
    if (uq.size() > 0 && upd_rdy) void'(uq.pop_front());
    if (e_pop) begin
      h = bq[0];
      uq.push_back({h.pc[3:0], res_t});
    end
    if (e_mis) begin
      m_flush = 1'b1;
      m_rpc = res_t ? h.tgt : h.pc + 16'd1;
      m_cnt = m_cnt + 16'd1;
      bq.delete();
      flush_left = FLUSH_CYC;
    end else begin
      m_flush = 1'b0;
      if (flush_left > 0) flush_left--;
      if (e_pop) void'(bq.pop_front());
      if (e_push) begin
        h.pc = id_pc; h.pred = id_pred; h.tgt = id_tgt;
        bq.push_back(h);
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] pc, input logic pr, input logic [15:0] tg,
                        input logic rv, input logic rt, input logic ur);
    id_v = v; id_pc = pc; id_pred = pr; id_tgt = tg; res_v = rv; res_t = rt; upd_rdy = ur;
  endtask

  // One clock: apply inputs, check against the model, advance both, then idle ID/RR.
  task automatic cyc(input logic v, input logic [15:0] pc, input logic pr, input logic [15:0] tg,
                     input logic rv, input logic rt, input logic ur);
    set_in(v, pc, pr, tg, rv, rt, ur);
    #1;
    check_all();
    model_step();
    @(posedge clk); #1;
    id_v = 1'b0; res_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 16'h0, 0, 16'h0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 16'h0, 0, 16'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_stall", stall_id, 0);
    chk("rst_cnt", mis_cnt, 0);
    chk("rst_err", err_uf, 0);

    // 1: correct prediction, update one cycle after resolve
    cyc(1, 16'h0005, 1, 16'h0040, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    chk("t1_flush", flush, 0);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_idx", upd_idx, 4'h5);
    chk("t1_upd_taken", upd_taken, 1);
    chk("t1_cnt", mis_cnt, 0);

    // 2: mispredict not-taken -> redirect to pc+1, two stall cycles
    cyc(1, 16'h0003, 1, 16'h0020, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0, 1);
    chk("t2_flush", flush, 1);
    chk("t2_redir_v", redir_v, 1);
    chk("t2_redir_pc", redir_pc, 16'h0004);
    chk("t2_stall1", stall_id, 1);
    chk("t2_cnt", mis_cnt, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    chk("t2_flush_pulse", flush, 0);
    chk("t2_stall2", stall_id, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    chk("t2_stall_end", stall_id, 0);

    // 3: pc wraps
    cyc(1, 16'hFFFF, 1, 16'h1234, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0, 1);
    chk("t3_redir_pc", redir_pc, 16'h0000);
    chk("t3_cnt", mis_cnt, 2);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);

    // 4: full FIFO stall, simultaneous push/pop keeps occupancy
    for (int i = 0; i < 4; i++) cyc(1, 16'h0100 + 16'(i), 1, 16'h0200, 0, 0, 1);
    set_in(1, 16'h0104, 1, 16'h0200, 0, 0, 1); #1;
    chk("t4_full_stall", stall_id, 1);
    cyc(1, 16'h0104, 1, 16'h0200, 0, 0, 1);
    set_in(1, 16'h0104, 1, 16'h0200, 1, 1, 1); #1;
    chk("t4_pushpop_stall", stall_id, 0);
    cyc(1, 16'h0104, 1, 16'h0200, 1, 1, 1);
    set_in(1, 16'h0105, 1, 16'h0200, 0, 0, 1); #1;
    chk("t4_still_full", stall_id, 1);
    cyc(1, 16'h0105, 1, 16'h0200, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 1);

    // 5: update backpressure, in-order drain
    cyc(1, 16'h0007, 1, 16'h0300, 0, 0, 1);
    cyc(1, 16'h0008, 0, 16'h0300, 0, 0, 1);
    cyc(1, 16'h0009, 1, 16'h0300, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    set_in(0, 16'h0000, 0, 16'h0000, 1, 1, 0); #1;
    chk("t5_res_ready_full", res_ready, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 0);
    set_in(0, 16'h0000, 0, 16'h0000, 1, 1, 1); #1;
    chk("t5_res_ready_drain", res_ready, 1);
    chk("t5_head0", upd_idx, 4'h7);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    chk("t5_head1_idx", upd_idx, 4'h8);
    chk("t5_head1_tk", upd_taken, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    chk("t5_head2_idx", upd_idx, 4'h9);
    chk("t5_head2_tk", upd_taken, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    chk("t5_drained", upd_valid, 0);

    // 6: underflow is sticky; reset mid-FLUSH with a pending update
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    chk("t6_err", err_uf, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    chk("t6_err_sticky", err_uf, 1);
    cyc(1, 16'h0010, 0, 16'h0080, 0, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1, 0);
    chk("t6_redir_pc", redir_pc, 16'h0080);
    chk("t6_upd_pending", upd_valid, 1);
    do_reset();
    #1;
    chk("t6_rst_stall", stall_id, 0);
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_cnt", mis_cnt, 0);
    chk("t6_rst_upd", upd_valid, 0);
    chk("t6_rst_err", err_uf, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 1) == 1, 16'($urandom), 1'($urandom), 16'($urandom),
            (bq.size() > 0) && ($urandom_range(0, 2) != 0), 1'($urandom),
            $urandom_range(0, 9) < 7);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
